// File: rtl/d_ext_pipe.sv
// -----------------------------------------------------------------------------
// d_ext_pipe
// Immediate extender with a registered, elastic output stage at the D-to-E
// boundary.
// It extends an IN_W-bit immediate to OUT_W bits in one of four modes and
// holds the result in a 2-entry skid buffer (a main register plus a skid
// register).
// in_ready is a pure register output, so a stall from downstream never creates
// a combinational path back into decode.
//
// Optional feature (macro EXT_BRANCH_TARGET_EN):
//   When this macro is defined, the block adds in_pc and out_target.
//   out_target = in_pc + 4 + ext. It is buffered alongside out_data and
//   follows the same flush and skid rules.
//
// Ports:
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous reset, active-low
//   flush      in   synchronous flush; drops every buffered entry and the
//                   input offered in the same cycle
//   in_valid   in   in_imm/in_mode valid
//   in_ready   out  block can accept this cycle (= !skid_valid)
//   in_imm     in   raw immediate field [IN_W]
//   in_mode    in   00 zero, 01 sign, 10 upper-load, 11 branch-offset
//   in_pc      in   [OUT_W] PC of the instruction (EXT_BRANCH_TARGET_EN only)
//   out_valid  out  out_data valid
//   out_ready  in   consumer accepts this cycle
//   out_data   out  extended result [OUT_W]
//   out_target out  branch target [OUT_W] (EXT_BRANCH_TARGET_EN only)
//
// Parameters:
//   IN_W  (16)  immediate width
//   OUT_W (32)  result width; OUT_W >= IN_W + 2
// -----------------------------------------------------------------------------
module d_ext_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
`ifdef EXT_BRANCH_TARGET_EN
  input  logic [OUT_W-1:0] in_pc,
  output logic [OUT_W-1:0] out_target,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data
);

  localparam int PAD_W = OUT_W - IN_W;

  logic [OUT_W-1:0] w_sext;
  logic [OUT_W-1:0] w_ext;
  logic             w_accept;
  logic             w_emit;

  logic             r_out_valid;
  logic [OUT_W-1:0] r_out_data;
  logic             r_skid_valid;
  logic [OUT_W-1:0] r_skid_data;

  // ---------------------------------------------------------------------------
  // Extension function
  // ---------------------------------------------------------------------------
  assign w_sext = {{PAD_W{in_imm[IN_W-1]}}, in_imm};

  always_comb begin
    w_ext = '0;
    unique case (in_mode)
      2'b00: w_ext = {{PAD_W{1'b0}}, in_imm};
      2'b01: w_ext = w_sext;
      2'b10: w_ext = {in_imm, {PAD_W{1'b0}}};
      // Word-offset branch: shifting out the top two sign bits is intended.
      2'b11: w_ext = w_sext << 2;
      default: w_ext = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------------
  assign in_ready  = ~r_skid_valid;
  assign w_accept  = in_valid & ~r_skid_valid;
  assign w_emit    = r_out_valid & out_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

  // ---------------------------------------------------------------------------
  // Main and skid registers.
  // A full skid means in_ready was low, so refilling main from the skid never
  // competes with a new accept. This keeps strict FIFO order.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
    end else if (flush) begin
      // Data registers keep their value; only the valid flags are cleared.
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (r_skid_valid) begin
      if (w_emit) begin
        r_out_data   <= r_skid_data;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
      end
    end else if (w_accept) begin
      if (!r_out_valid || w_emit) begin
        r_out_data  <= w_ext;
        r_out_valid <= 1'b1;
      end else begin
        r_skid_data  <= w_ext;
        r_skid_valid <= 1'b1;
      end
    end else if (w_emit) begin
      r_out_valid <= 1'b0;
    end
  end

`ifdef EXT_BRANCH_TARGET_EN
  // ---------------------------------------------------------------------------
  // Branch target path. It is loaded under the same conditions as the data
  // path, so the target always travels with its immediate.
  // ---------------------------------------------------------------------------
  logic [OUT_W-1:0] w_target;
  logic [OUT_W-1:0] r_out_target;
  logic [OUT_W-1:0] r_skid_target;

  assign w_target   = in_pc + OUT_W'(4) + w_ext;
  assign out_target = r_out_target;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_target  <= '0;
      r_skid_target <= '0;
    end else if (!flush) begin
      if (r_skid_valid) begin
        if (w_emit) r_out_target <= r_skid_target;
      end else if (w_accept) begin
        if (!r_out_valid || w_emit) r_out_target  <= w_target;
        else                        r_skid_target <= w_target;
      end
    end
  end
`endif

endmodule

// File: tb/tb_d_ext_pipe.sv
// -----------------------------------------------------------------------------
// tb_d_ext_pipe
// Directed, table-driven bench for d_ext_pipe (IN_W=16, OUT_W=32).
// The bench drives inputs just after a rising edge and checks outputs 1 ns
// after the next rising edge.
// Define EXT_BRANCH_TARGET_EN to also exercise the branch-target path.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_d_ext_pipe;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_imm;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
`ifdef EXT_BRANCH_TARGET_EN
  logic [31:0] in_pc;
  logic [31:0] out_target;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  d_ext_pipe #(.IN_W(16), .OUT_W(32)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_imm     (in_imm),
    .in_mode    (in_mode),
`ifdef EXT_BRANCH_TARGET_EN
    .in_pc      (in_pc),
    .out_target (out_target),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data)
  );

  typedef struct {
    logic [15:0] imm;
    logic [1:0]  mode;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_q [8];

    // Hand-computed expected values: zero, sign, upper and branch modes.
    vecs[0] = '{16'h8001, 2'b01, 32'hFFFF8001};
    vecs[1] = '{16'h8001, 2'b00, 32'h00008001};
    vecs[2] = '{16'h8001, 2'b10, 32'h80010000};
    vecs[3] = '{16'h8001, 2'b11, 32'hFFFE0004};
    vecs[4] = '{16'h7FFF, 2'b01, 32'h00007FFF};
    vecs[5] = '{16'h7FFF, 2'b11, 32'h0001FFFC};
    vecs[6] = '{16'hFFFF, 2'b10, 32'hFFFF0000};
    vecs[7] = '{16'hFFFF, 2'b00, 32'h0000FFFF};
    vecs[8] = '{16'hFFFF, 2'b11, 32'hFFFFFFFC};

    reset_n   = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_imm    = '0;
    in_mode   = '0;
    out_ready = 1'b0;
`ifdef EXT_BRANCH_TARGET_EN
    in_pc     = '0;
`endif

    // ---------------- reset state ----------------
    repeat (3) tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  out_data,       32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    // Release reset away from the clock edge; a flush during reset must do nothing.
    flush = 1'b1;
    #2 reset_n = 1'b1;
    flush = 1'b0;
    tick();
    check("post_rst_out_valid", 32'(out_valid), 32'd0);

    // ---------------- extension modes (table) ----------------
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1;
      in_imm   = vecs[i].imm;
      in_mode  = vecs[i].mode;
      check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'd1);
      tick();
      $display("[TB] vec %0d imm=0x%04h mode=%0d data=0x%08h exp=0x%08h",
               i, vecs[i].imm, vecs[i].mode, out_data, vecs[i].exp);
      check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("vec%0d_data", i),  out_data,       vecs[i].exp);
    end
    in_valid = 1'b0;
    tick();
    check("drain_valid", 32'(out_valid), 32'd0);

    // ---------------- streaming ----------------
    for (int i = 0; i < 8; i++) exp_q[i] = 32'(16'h1111 * (i + 1));
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_imm   = 16'(16'h1111 * (i + 1));
      in_mode  = 2'b00;
      tick();
      $display("[TB] stream %0d data=0x%08h", i, out_data);
      check($sformatf("stream%0d_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("stream%0d_data", i),  out_data,       exp_q[i]);
      check($sformatf("stream%0d_ready", i), 32'(in_ready),  32'd1);
    end
    in_valid = 1'b0;
    tick();
    check("stream_end_valid", 32'(out_valid), 32'd0);

    // ---------------- backpressure ----------------
    out_ready = 1'b0;
    in_valid  = 1'b1; in_imm = 16'h0001; in_mode = 2'b01;
    tick();
    check("bp_A_valid", 32'(out_valid), 32'd1);
    check("bp_A_data",  out_data,       32'h00000001);
    check("bp_A_ready", 32'(in_ready),  32'd1);
    in_imm = 16'h0002; in_mode = 2'b00;
    tick();
    in_valid = 1'b0;
    check("bp_B_in_ready", 32'(in_ready), 32'd0);
    check("bp_B_hold_A",   out_data,      32'h00000001);
    tick();
    check("bp_stall_data",  out_data,      32'h00000001);
    check("bp_stall_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    tick();
    $display("[TB] bp emit A then data=0x%08h", out_data);
    check("bp_B_valid",       32'(out_valid), 32'd1);
    check("bp_B_data",        out_data,       32'h00000002);
    check("bp_ready_after_A", 32'(in_ready),  32'd1);
    tick();
    check("bp_empty", 32'(out_valid), 32'd0);

    // ---------------- flush with a full skid ----------------
    out_ready = 1'b0;
    in_valid = 1'b1; in_imm = 16'h0011; in_mode = 2'b00;
    tick();
    in_imm = 16'h0022;
    tick();
    check("fl_full", 32'(in_ready), 32'd0);
    flush = 1'b1; in_imm = 16'h7FFF;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_out_valid", 32'(out_valid), 32'd0);
    check("fl_in_ready",  32'(in_ready),  32'd1);
    // Flush while in_ready=1: the offered input must still be dropped.
    flush = 1'b1; in_valid = 1'b1; in_imm = 16'h7FFF;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check("fl_drop_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("fl_never_%0d", i), 32'(out_valid), 32'd0);
    end

    // ---------------- async reset mid-backpressure ----------------
    out_ready = 1'b0;
    in_valid = 1'b1; in_imm = 16'h0033; in_mode = 2'b00;
    tick();
    in_imm = 16'h0044;
    tick();
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("ar_out_valid", 32'(out_valid), 32'd0);
    check("ar_out_data",  out_data,       32'd0);
    check("ar_in_ready",  32'(in_ready),  32'd1);
    #3 reset_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("ar_no_stale_%0d", i), 32'(out_valid), 32'd0);
    end

`ifdef EXT_BRANCH_TARGET_EN
    // ---------------- branch target ----------------
    in_valid = 1'b1; in_mode = 2'b11; in_imm = 16'hFFFF; in_pc = 32'h00003000;
    tick();
    check("bt_data",   out_data,   32'hFFFFFFFC);
    check("bt_target", out_target, 32'h00003000);
    in_imm = 16'h0001; in_pc = 32'hFFFFFFFC;
    tick();
    in_valid = 1'b0;
    check("bt_wrap_target", out_target, 32'h00000004);
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
